// File: rtl/cvm300_frame_sequencer.sv
// cvm300_frame_sequencer: sequences one CVM300 frame capture (FIFO reset, FRAME_REQ, line tracking, status).
// Define CVM_SEQ_CONTINUOUS_EN to re-arm frames back-to-back while start stays high.
module cvm300_frame_sequencer #(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned REQ_WIDTH       = 1,
  parameter int unsigned LINES_PER_FRAME = 488,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             FSM_Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             data_valid,
  input  logic             fifo_full,
  output logic             fifo_wr_rst,
  output logic             fifo_rd_rst,
  output logic             frame_req,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic             overflow_err,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] frame_count,
  output logic [7:0]       state_dbg
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIFO_RST  = 3'd1,
    SETTLE    = 3'd2,
    REQ       = 3'd3,
    WAIT_DATA = 3'd4,
    CAPTURE   = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] LPF = CNT_W'(LINES_PER_FRAME);
  state_t state_q, state_d;
  logic [2:0] start_sync_q, start_sync_d, dv_sync_q, dv_sync_d;
  logic [1:0] abort_sync_q, abort_sync_d;
  logic [31:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] line_count_q, line_count_d, frame_count_q, frame_count_d;
  logic timeout_err_q, timeout_err_d, overflow_err_q, overflow_err_d;
  logic start_rise, abort_s, dv_rise, dv_fall, rearm;
  assign start_rise = start_sync_q[1] & ~start_sync_q[2];
  assign abort_s    = abort_sync_q[1];
  assign dv_rise    = dv_sync_q[1] & ~dv_sync_q[2];
  assign dv_fall    = ~dv_sync_q[1] & dv_sync_q[2];
`ifdef CVM_SEQ_CONTINUOUS_EN
  assign rearm = start_sync_q[1] & ~abort_s;
`else
  assign rearm = 1'b0;
`endif
  always_comb begin
    start_sync_d   = {start_sync_q[1:0], start};
    abort_sync_d   = {abort_sync_q[0], abort};
    dv_sync_d      = {dv_sync_q[1:0], data_valid};
    state_d        = state_q;
    cnt_d          = cnt_q + 32'd1;
    line_count_d   = line_count_q;
    frame_count_d  = frame_count_q;
    timeout_err_d  = timeout_err_q;
    overflow_err_d = overflow_err_q | (fifo_full & (state_q == WAIT_DATA || state_q == CAPTURE));
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_rise && !abort_s) begin
          state_d        = FIFO_RST;
          timeout_err_d  = 1'b0;
          overflow_err_d = 1'b0;
          line_count_d   = '0;
        end
      end
      FIFO_RST: if (cnt_q == RST_CYCLES - 1) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: if (cnt_q == SETTLE_CYCLES - 1) begin
        state_d = REQ;
        cnt_d   = '0;
      end
      REQ: if (cnt_q == REQ_WIDTH - 1) begin
        state_d = WAIT_DATA;
        cnt_d   = '0;
      end
      WAIT_DATA: begin
        if (dv_rise) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) state_d = ERROR;
      end
      CAPTURE: begin
        if (dv_rise || dv_fall) cnt_d = '0;
        else if (cnt_q == TIMEOUT_CYCLES - 1) state_d = ERROR;
        if (dv_fall) begin
          line_count_d = line_count_q + 1'b1;
          if (line_count_d == LPF) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d         = '0;
        frame_count_d = frame_count_q + 1'b1;
        state_d       = rearm ? FIFO_RST : IDLE;
        line_count_d  = rearm ? '0 : line_count_q;
      end
      ERROR: begin
        cnt_d         = '0;
        timeout_err_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // DONE already committed its pulse, so abort only cancels frames still in flight
    if (abort_s && state_q != IDLE && state_q != DONE) begin
      state_d      = IDLE;
      cnt_d        = '0;
      line_count_d = line_count_q;
    end
  end
  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      start_sync_q   <= '0;
      abort_sync_q   <= '0;
      dv_sync_q      <= '0;
      cnt_q          <= '0;
      line_count_q   <= '0;
      frame_count_q  <= '0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_sync_q   <= start_sync_d;
      abort_sync_q   <= abort_sync_d;
      dv_sync_q      <= dv_sync_d;
      cnt_q          <= cnt_d;
      line_count_q   <= line_count_d;
      frame_count_q  <= frame_count_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end
  assign fifo_wr_rst  = state_q == FIFO_RST;
  assign fifo_rd_rst  = state_q == FIFO_RST;
  assign frame_req    = state_q == REQ;
  assign busy         = state_q != IDLE;
  assign frame_done   = state_q == DONE;
  assign timeout_err  = timeout_err_q;
  assign overflow_err = overflow_err_q;
  assign line_count   = line_count_q;
  assign frame_count  = frame_count_q;
  assign state_dbg    = {5'd0, state_q};
endmodule

// File: tb/tb_cvm300_frame_sequencer.sv
// tb_cvm300_frame_sequencer: randomized frame scenarios scored against per-frame expected outcomes.
`timescale 1ns/1ps
module tb_cvm300_frame_sequencer;
  localparam int RST = 4, SET = 4, REQW = 2, LINES = 3, TO = 100, CW = 16;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, data_valid = 1'b0, fifo_full = 1'b0;
  logic fifo_wr_rst, fifo_rd_rst, frame_req, busy, frame_done, timeout_err, overflow_err;
  logic [CW-1:0] line_count, frame_count;
  logic [7:0] state_dbg;
  int cyc = 0, n_cmp = 0, n_fail = 0, fc = 0;
  bit mon_en = 1'b0;
  typedef struct {int cyc; int done; int lines; int fc; int terr; int oerr;} end_t;
  int req_q[$];
  end_t end_q[$];
  cvm300_frame_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .REQ_WIDTH(REQW),
    .LINES_PER_FRAME(LINES), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .FSM_Clk(clk), .reset(reset), .start(start), .abort(abort), .data_valid(data_valid),
    .fifo_full(fifo_full), .fifo_wr_rst(fifo_wr_rst), .fifo_rd_rst(fifo_rd_rst),
    .frame_req(frame_req), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .overflow_err(overflow_err), .line_count(line_count), .frame_count(frame_count),
    .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Monitor: scores each frame_req pulse and each end of a busy period against queued expectations
  initial begin
    int rst_len, req_len, done_n, r;
    bit busy_p, req_p;
    end_t e;
    rst_len = 0; req_len = 0; done_n = 0; busy_p = 0; req_p = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !busy_p) begin
          rst_len = 0;
          done_n = 0;
        end
        if (busy && fifo_wr_rst && fifo_rd_rst) rst_len++;
        if (frame_done) done_n++;
        if (frame_req && !req_p) begin
          chk("pending_req", int'(req_q.size() > 0), 1);
          if (req_q.size() > 0) begin
            r = req_q.pop_front();
            chk("req_rise_cycle", cyc, r);
            chk("fifo_rst_len", rst_len, RST);
            chk("state_at_req", int'(state_dbg), 3);
            chk("terr_cleared", int'(timeout_err), 0);
            chk("oerr_cleared", int'(overflow_err), 0);
            chk("lines_cleared", int'(line_count), 0);
          end
          req_len = 0;
        end
        if (frame_req) req_len++;
        if (!frame_req && req_p) chk("req_width", req_len, REQW);
        if (!busy && busy_p) begin
          chk("pending_end", int'(end_q.size() > 0), 1);
          if (end_q.size() > 0) begin
            e = end_q.pop_front();
            chk("end_cycle", cyc, e.cyc);
            chk("done_pulses", done_n, e.done);
            chk("line_count", int'(line_count), e.lines);
            chk("frame_count", int'(frame_count), e.fc);
            chk("timeout_err", int'(timeout_err), e.terr);
            chk("overflow_err", int'(overflow_err), e.oerr);
            chk("state_idle", int'(state_dbg), 0);
          end
        end
        busy_p = busy;
        req_p = frame_req;
      end
    end
  end
  // kind 0: clean frame, 1: frame with fifo_full during capture, 2: no data (timeout), 3: abort after line 1
  task automatic run_frame(input int kind);
    int c, rise, h;
    end_t e;
    c = cyc;
    start = 1'b1;
    rise = c + 3 + RST + SET;
    req_q.push_back(rise);
    if (kind == 2) begin
      e = '{rise + REQW + TO + 1, 0, 0, fc, 1, 0};
      end_q.push_back(e);
    end
    tick(3);
    start = 1'b0;
    if (kind == 0) begin
      fifo_full = 1'b1;
      start = 1'b1;
      tick(2);
      fifo_full = 1'b0;
      start = 1'b0;
    end
    if (kind != 2) begin
      tick(rise + REQW - cyc + int'($urandom_range(0, 10)));
      for (int l = 0; l < LINES; l++) begin
        h = int'($urandom_range(1, 5));
        data_valid = 1'b1;
        if (kind == 1 && l == 0) fifo_full = 1'b1;
        tick(1);
        fifo_full = 1'b0;
        tick(h - 1);
        data_valid = 1'b0;
        if (kind == 3) begin
          tick(5);
          abort = 1'b1;
          e = '{cyc + 3, 0, 1, fc, 0, 0};
          end_q.push_back(e);
          tick(4);
          start = 1'b1;
          tick(2);
          start = 1'b0;
          tick(10);
          abort = 1'b0;
          break;
        end
        if (l == LINES - 1) begin
          e = '{cyc + 4, 1, LINES, fc + 1, 0, int'(kind == 1)};
          end_q.push_back(e);
          fc++;
        end
        tick(int'($urandom_range(1, 6)));
      end
    end
    for (int i = 0; i < 400 && busy; i++) tick(1);
    chk("frame_terminates", int'(busy), 0);
    tick(4);
  endtask
  initial begin
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_req", int'(frame_req), 0);
    chk("rst_wr_rst", int'(fifo_wr_rst), 0);
    chk("rst_rd_rst", int'(fifo_rd_rst), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_overflow_err", int'(overflow_err), 0);
    chk("rst_line_count", int'(line_count), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_state", int'(state_dbg), 0);
    reset = 1'b0;
    tick(2);
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) run_frame(i < 4 ? i : int'($urandom_range(0, 3)));
    tick(5);
    chk("req_q_drained", req_q.size(), 0);
    chk("end_q_drained", end_q.size(), 0);
    mon_en = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20 && !fifo_wr_rst; i++) tick(1);
    chk("midframe_in_fifo_rst", int'(fifo_wr_rst), 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_wr_rst", int'(fifo_wr_rst), 0);
    chk("async_rst_rd_rst", int'(fifo_rd_rst), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_frame_count", int'(frame_count), 0);
    chk("async_rst_state", int'(state_dbg), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
